// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//
// Writer side of the register file's single write port. Fixed-latency ALU
// results and variable-latency load results share one registered write
// (rf_we / rf_waddr / rf_wdata) per cycle. Loads wait in a small FIFO. The
// ALU always wins the port, because it has no back-pressure.
//
// An ALU result is always younger than any load that is queued or arriving.
// When an ALU write to rd R is selected, the arbiter handles older loads to R
// as follows:
//   - Queued loads to R are invalidated in place. They keep their slot and
//     pop later without a write.
//   - A load to R that arrives in the same cycle is accepted and dropped.
//
// The issue stage uses q_pend1/q_pend2 for RAW stalls. A pending bit is set
// when the queried register has either:
//   - a live FIFO entry, or
//   - a write sitting on rf_* that the register file has not yet committed.
// x0 is never written and is never pending.
//
// Parameters
//   XLEN   data width of results and the write port
//   AW     register address width
//   DEPTH  load FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data        ALU result (no back-pressure)
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  load result handshake
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   q_addr1/q_addr2                  issue-stage source addresses
//   q_pend1/q_pend2                  write to that source is in flight
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   q_addr1,
  input  logic [AW-1:0]   q_addr2,
  output logic            q_pend1,
  output logic            q_pend2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // FIFO storage. Per-slot valid bits live beside the pointers: a slot can be
  // occupied (between rptr and wptr) yet hold no write after an ALU override.
  logic [AW-1:0]    fifo_rd_reg   [DEPTH];
  logic [XLEN-1:0]  fifo_data_reg [DEPTH];
  logic [DEPTH-1:0] fifo_vld_reg;
  logic [DEPTH-1:0] fifo_vld_next;
  logic [PW-1:0]    wptr_reg;
  logic [PW-1:0]    rptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  logic            rf_we_reg;
  logic [AW-1:0]   rf_waddr_reg;
  logic [XLEN-1:0] rf_wdata_reg;

  logic alu_sel;
  logic lsu_xfer;
  logic push;
  logic pop;
  logic head_live;

  logic [DEPTH-1:0] kill_vec;
  logic [DEPTH-1:0] match1_vec;
  logic [DEPTH-1:0] match2_vec;

  // Readiness depends on occupancy only. A full FIFO refuses a load even in a
  // cycle where it also pops.
  assign lsu_ready = !rst && (count_reg < DEPTH_C);
  assign lsu_xfer  = lsu_valid && lsu_ready;

  assign alu_sel = alu_valid && (alu_rd != '0);

  // Two kinds of transferred load are consumed without being stored:
  //   - a load to x0;
  //   - a load to the register the ALU is writing this cycle.
  assign push = lsu_xfer && (lsu_rd != '0) && !(alu_sel && (lsu_rd == alu_rd));

  // The head slot leaves whenever the ALU does not own the port. It only
  // produces a write if it is still live.
  assign pop       = !alu_sel && (count_reg != '0);
  assign head_live = fifo_vld_reg[rptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Gate with the valid bit so never-written slots cannot match.
      assign kill_vec[gi]   = alu_sel && fifo_vld_reg[gi] && (fifo_rd_reg[gi] == alu_rd);
      assign match1_vec[gi] = fifo_vld_reg[gi] && (fifo_rd_reg[gi] == q_addr1);
      assign match2_vec[gi] = fifo_vld_reg[gi] && (fifo_rd_reg[gi] == q_addr2);

      // Push never targets a slot that is being killed or popped: a pushed rd
      // never matches the ALU rd, and push and pop share a slot only when full.
      assign fifo_vld_next[gi] =
          (push && (wptr_reg == PW'(gi)))                      ? 1'b1 :
          (kill_vec[gi] || (pop && (rptr_reg == PW'(gi))))     ? 1'b0 :
                                                                 fifo_vld_reg[gi];
    end
  endgenerate

  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_vld_reg <= '0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
    end else begin
      fifo_vld_reg <= fifo_vld_next;
      count_reg    <= count_next;
      if (push) begin
        wptr_reg <= wptr_reg + PW'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PW'(1);
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_reg[wptr_reg]   <= lsu_rd;
      fifo_data_reg[wptr_reg] <= lsu_data;
    end
  end

  // Registered write port. Address and data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else if (alu_sel) begin
      rf_we_reg    <= 1'b1;
      rf_waddr_reg <= alu_rd;
      rf_wdata_reg <= alu_data;
    end else if (pop && head_live) begin
      rf_we_reg    <= 1'b1;
      rf_waddr_reg <= fifo_rd_reg[rptr_reg];
      rf_wdata_reg <= fifo_data_reg[rptr_reg];
    end else begin
      rf_we_reg <= 1'b0;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

  // An ALU result in its input cycle is deliberately absent here; the issue
  // stage bypass network covers that case.
  assign q_pend1 = (q_addr1 != '0) &&
                   ((|match1_vec) || (rf_we_reg && (rf_waddr_reg == q_addr1)));
  assign q_pend2 = (q_addr2 != '0) &&
                   ((|match2_vec) || (rf_we_reg && (rf_waddr_reg == q_addr2)));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_write_arbiter
//
// Self-checking bench for wb_write_arbiter.
//
// Reference model
//   The model is a queue of pending loads, each with a live flag. Each cycle
//   it applies the write-selection rules directly:
//     - a nonzero ALU write wins and kills older loads to the same rd;
//     - otherwise the queue head pops and writes only if it is still live.
//
// Tests
//   - Directed scenarios, one task each.
//   - A randomized run with a well-behaved LSU. The LSU holds rd/data until
//     each load transfers.
//
// Shadow register file
//   A shadow register file records every write the DUT commits, so final
//   register values can be checked.
// -----------------------------------------------------------------------------
module tb_wb_write_arbiter;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   q_addr1;
  logic [AW-1:0]   q_addr2;
  logic            q_pend1;
  logic            q_pend2;

  int n_checks = 0;
  int n_fail   = 0;

  wb_write_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_pend1   (q_pend1),
    .q_pend2   (q_pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file fed by the DUT's committed writes.
  logic [XLEN-1:0] dut_rf [32];
  always @(posedge clk) begin
    if (rf_we) dut_rf[rf_waddr] <= rf_wdata;
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    bit              live;
  } ent_t;

  ent_t            m_q[$];
  logic            m_we;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;

  function automatic bit m_ready();
    return !rst && (m_q.size() < DEPTH);
  endfunction

  function automatic bit m_pend(logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_we && m_waddr == a) return 1'b1;
    foreach (m_q[i]) if (m_q[i].live && m_q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  // The task then waits for the edge and returns 1 time unit after it.
  task automatic tick();
    bit   rdy;
    bit   alu_take;
    ent_t e;
    rdy = m_ready();
    if (rst) begin
      m_q.delete();
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      alu_take = alu_valid && (alu_rd != 0);
      m_we = 1'b0;
      if (alu_take) begin
        foreach (m_q[i]) if (m_q[i].rd == alu_rd) m_q[i].live = 1'b0;
        m_we    = 1'b1;
        m_waddr = alu_rd;
        m_wdata = alu_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e.live) begin
          m_we    = 1'b1;
          m_waddr = e.rd;
          m_wdata = e.data;
        end
      end
      if (lsu_valid && rdy && lsu_rd != 0 && !(alu_take && lsu_rd == alu_rd)) begin
        e.rd   = lsu_rd;
        e.data = lsu_data;
        e.live = 1'b1;
        m_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    q_addr1 = 5'd5;
    q_addr2 = 5'd0;
    tick();
    tick();
    n_checks++;
    if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %0b want 0", lsu_ready); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", rf_we); end
    n_checks++;
    if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    n_checks++;
    if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    n_checks++;
    if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", lsu_ready); end
    n_checks++;
    if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %0b%0b want 00", q_pend1, q_pend2); end
    $display("test_reset done");
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    q_addr1   = 5'd5;
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %0b want 1", rf_we); end
    n_checks++;
    if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr); end
    n_checks++;
    if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata: got %h want deadbeef", rf_wdata); end
    n_checks++;
    if (q_pend1 !== 1'b1) begin n_fail++; $display("FAIL alu_pend: got %0b want 1", q_pend1); end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_after: got %0b want 0", rf_we); end
    n_checks++;
    if (q_pend1 !== 1'b0) begin n_fail++; $display("FAIL alu_pend_after: got %0b want 0", q_pend1); end
    $display("test_alu_write: x5 <= %h", rf_wdata);
  endtask

  task automatic test_fifo_fill_order();
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1;
      alu_rd    = AW'(16 + i);
      alu_data  = $urandom;
      lsu_valid = 1'b1;
      lsu_rd    = AW'(i);
      lsu_data  = 32'h100 + 32'(i);
      #1;
      n_checks++;
      if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %0b want 1", i, lsu_ready); end
      tick();
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== AW'(16 + i)) begin n_fail++; $display("FAIL fill_alu_%0d: got we=%0b rd=%0d want we=1 rd=%0d", i, rf_we, rf_waddr, 16 + i); end
    end
    idle_inputs();
    #1;
    n_checks++;
    if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %0b want 0", lsu_ready); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== AW'(k) || rf_wdata !== 32'h100 + 32'(k)) begin
        n_fail++;
        $display("FAIL drain_%0d: got we=%0b rd=%0d data=%h want we=1 rd=%0d data=%h", k, rf_we, rf_waddr, rf_wdata, k, 32'h100 + 32'(k));
      end
      $display("test_fifo_fill_order: pop %0d x%0d <= %h", k, rf_waddr, rf_wdata);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %0b want 0", rf_we); end
  endtask

  task automatic test_alu_overrides_load();
    lsu_valid = 1'b1;
    lsu_rd    = 5'd7;
    lsu_data  = 32'h11;
    q_addr1   = 5'd7;
    tick();
    lsu_valid = 1'b0;
    #1;
    n_checks++;
    if (q_pend1 !== 1'b1) begin n_fail++; $display("FAIL ovr_pend_queued: got %0b want 1", q_pend1); end
    alu_valid = 1'b1;
    alu_rd    = 5'd7;
    alu_data  = 32'h22;
    tick();
    alu_valid = 1'b0;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22) begin n_fail++; $display("FAIL ovr_alu: got we=%0b rd=%0d data=%h want we=1 rd=7 data=22", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ovr_dead_pop: got we=%0b want 0", rf_we); end
    n_checks++;
    if (q_pend1 !== 1'b0) begin n_fail++; $display("FAIL ovr_pend_after: got %0b want 0", q_pend1); end
    tick();
    n_checks++;
    if (dut_rf[7] !== 32'h22) begin n_fail++; $display("FAIL ovr_x7: got %h want 22", dut_rf[7]); end
    $display("test_alu_overrides_load: x7 = %h", dut_rf[7]);
  endtask

  task automatic test_same_cycle_drop();
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h1234;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd9;
    lsu_data  = 32'h99;
    #1;
    n_checks++;
    if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %0b want 1", lsu_ready); end
    tick();
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL drop_alu: got we=%0b rd=%0d data=%h want we=1 rd=9 data=1234", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drop_no_load: got %0b want 0", rf_we); end
    tick();
    n_checks++;
    if (dut_rf[9] !== 32'h1234) begin n_fail++; $display("FAIL drop_x9: got %h want 1234", dut_rf[9]); end
    $display("test_same_cycle_drop: x9 = %h", dut_rf[9]);
  endtask

  task automatic test_x0_filter();
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hAAAA5555;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd0;
    lsu_data  = 32'h5555AAAA;
    q_addr1   = 5'd0;
    q_addr2   = 5'd0;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0b want 0", rf_we); end
    n_checks++;
    if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin n_fail++; $display("FAIL x0_pend: got %0b%0b want 00", q_pend1, q_pend2); end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we_late: got %0b want 0", rf_we); end
    $display("test_x0_filter: rf_we=%0b", rf_we);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'd20;
      alu_data  = $urandom;
      lsu_valid = 1'b1;
      lsu_rd    = AW'(10 + i);
      lsu_data  = $urandom;
      tick();
    end
    idle_inputs();
    q_addr1 = 5'd10;
    q_addr2 = 5'd12;
    #1;
    n_checks++;
    if (q_pend1 !== 1'b1) begin n_fail++; $display("FAIL rmid_pend_before: got %0b want 1", q_pend1); end
    rst = 1'b1;
    tick();
    n_checks++;
    if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %0b want 0", lsu_ready); end
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_in_rst: got %0b want 0", rf_we); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rmid_no_write_%0d: got we=%0b rd=%0d want we=0", k, rf_we, rf_waddr); end
    end
    n_checks++;
    if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin n_fail++; $display("FAIL rmid_pend_after: got %0b%0b want 00", q_pend1, q_pend2); end
    // Four loads must fit again, proving occupancy returned to zero.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'd21;
      alu_data  = $urandom;
      lsu_valid = 1'b1;
      lsu_rd    = AW'(24 + i);
      lsu_data  = $urandom;
      #1;
      n_checks++;
      if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_refill_ready_%0d: got %0b want 1", i, lsu_ready); end
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (dut_rf[10] !== 32'd0) begin n_fail++; $display("FAIL rmid_x10: got %h want 0", dut_rf[10]); end
    $display("test_reset_mid: x10 = %h", dut_rf[10]);
  endtask

  task automatic test_random();
    bit xfer;
    int nwrites = 0;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd    = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      if (!lsu_valid) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = AW'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      q_addr1 = AW'($urandom_range(0, 7));
      q_addr2 = AW'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (lsu_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, lsu_ready, m_ready()); end
      n_checks++;
      if (q_pend1 !== m_pend(q_addr1) || q_pend2 !== m_pend(q_addr2)) begin
        n_fail++;
        $display("FAIL rnd_pend c%0d: a1=%0d a2=%0d got %0b%0b want %0b%0b", c, q_addr1, q_addr2, q_pend1, q_pend2, m_pend(q_addr1), m_pend(q_addr2));
      end
      xfer = lsu_valid && m_ready();
      tick();
      if (xfer) lsu_valid = 1'b0;
      n_checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL rnd_write c%0d: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      if (m_we) nwrites++;
    end
    rst = 1'b0;
    idle_inputs();
    $display("test_random: 600 cycles, %0d writes", nwrites);
  endtask

  // Hard time bound so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) dut_rf[r] = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    q_addr1 = '0;
    q_addr2 = '0;
    test_reset();
    test_alu_write();
    test_fifo_fill_order();
    test_alu_overrides_load();
    test_same_cycle_drop();
    test_x0_filter();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
